// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared state encoding and fast-simulation timing constants
// Contents: steer_state_t (value shown on state_o), FAST_* cycle counts, max_int helper.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    STEER   = 2'd2,
    STEPOFF = 2'd3
  } steer_state_t;

  localparam int FAST_SETTLE_CYC  = 32768;
  localparam int FAST_STEPOFF_CYC = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/steer_en_gen_if.sv
// rtl/steer_en_gen_if.sv - load-cell sample bus between sampler (master) and controller (slave)
// Signals: ld_vld (sample strobe), lft_ld / rght_ld (LD_W-bit unsigned load-cell samples).
interface steer_en_gen_if #(
  parameter int LD_W = 12
) ();

  logic            ld_vld;
  logic [LD_W-1:0] lft_ld;
  logic [LD_W-1:0] rght_ld;

  modport master (output ld_vld, output lft_ld, output rght_ld);
  modport slave  (input  ld_vld, input  lft_ld, input  rght_ld);

endinterface

// File: rtl/steer_cmp.sv
// rtl/steer_cmp.sv - weight/imbalance flag generation, registered on valid samples
// Ports: clk, rst (sync, active-high), ld_vld, lft_ld, rght_ld in;
//        gt_o, lt_o, d14_o, d1516_o registered flags out (held between strobes).
module steer_cmp #(
  parameter int LD_W         = 12,
  parameter int MIN_RIDER_WT = 'h200,
  parameter int WT_HYST      = 'h40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_vld,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic            gt_o,
  output logic            lt_o,
  output logic            d14_o,
  output logic            d1516_o
);

  // One extra bit so the sum of two full-scale samples never truncates.
  localparam int SW = LD_W + 1;
  localparam logic [SW-1:0] HI_TH = SW'(MIN_RIDER_WT + WT_HYST);
  localparam logic [SW-1:0] LO_TH = SW'(MIN_RIDER_WT - WT_HYST);

  if (WT_HYST > MIN_RIDER_WT) begin : g_bad_hyst
    $error("steer_cmp: WT_HYST must not exceed MIN_RIDER_WT");
  end

  logic [LD_W-1:0] diff;
  logic [SW-1:0]   sum_d;
  logic [SW-1:0]   adiff_d;
  logic [SW-1:0]   quart_d;
  logic [SW-1:0]   f1516_d;

  always_comb begin
    diff    = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    sum_d   = {1'b0, lft_ld} + {1'b0, rght_ld};
    adiff_d = {1'b0, diff};
    quart_d = sum_d >> 2;
    // 15/16 of the sum, rounded up: subtracting the floored 1/16 rounds the result up.
    f1516_d = sum_d - (sum_d >> 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_o    <= 1'b0;
      lt_o    <= 1'b0;
      d14_o   <= 1'b0;
      d1516_o <= 1'b0;
    end else if (ld_vld) begin
      gt_o    <= sum_d > HI_TH;
      lt_o    <= sum_d < LO_TH;
      d14_o   <= adiff_d > quart_d;
      d1516_o <= adiff_d > f1516_d;
    end
  end

endmodule

// File: rtl/steer_en_gen.sv
// rtl/steer_en_gen.sv - rider-presence / steering-enable controller (timer + FSM)
// Ports: clk, rst (sync, active-high), ld_if (slave sample bus);
//        en_steer, rider_off, steer_lost (registered Moore outputs), state_o (current state).
module steer_en_gen
  import steer_pkg::*;
#(
  parameter int LD_W         = 12,
  parameter int MIN_RIDER_WT = 'h200,
  parameter int WT_HYST      = 'h40,
  parameter int SETTLE_CYC   = 67_000_000,
  parameter int STEPOFF_CYC  = 1_000_000,
  parameter bit FAST_SIM     = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  steer_en_gen_if.slave  ld_if,
  output logic           en_steer,
  output logic           rider_off,
  output logic           steer_lost,
  output logic [1:0]     state_o
);

  localparam int SETTLE_N  = FAST_SIM ? FAST_SETTLE_CYC  : SETTLE_CYC;
  localparam int STEPOFF_N = FAST_SIM ? FAST_STEPOFF_CYC : STEPOFF_CYC;
  localparam int TMR_W     = $clog2(max_int(SETTLE_N, STEPOFF_N));
  localparam logic [TMR_W-1:0] SETTLE_LAST  = TMR_W'(SETTLE_N - 1);
  localparam logic [TMR_W-1:0] STEPOFF_LAST = TMR_W'(STEPOFF_N - 1);

  logic gt, lt, d14, d1516;

  steer_cmp #(
    .LD_W         (LD_W),
    .MIN_RIDER_WT (MIN_RIDER_WT),
    .WT_HYST      (WT_HYST)
  ) u_cmp (
    .clk     (clk),
    .rst     (rst),
    .ld_vld  (ld_if.ld_vld),
    .lft_ld  (ld_if.lft_ld),
    .rght_ld (ld_if.rght_ld),
    .gt_o    (gt),
    .lt_o    (lt),
    .d14_o   (d14),
    .d1516_o (d1516)
  );

  steer_state_t     state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             tmr_clr;
  logic             lost_d;

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gt) state_d = SETTLE;
      end
      SETTLE: begin
        if (lt)                        state_d = IDLE;
        else if (d14)                  tmr_clr = 1'b1;  // imbalance restarts the full settle count
        else if (tmr_q == SETTLE_LAST) state_d = STEER;
      end
      STEER: begin
        if (lt)         state_d = IDLE;
        else if (d1516) state_d = STEPOFF;
      end
      STEPOFF: begin
        if (lt)                         state_d = IDLE;
        else if (!d1516)                state_d = STEER;
        else if (tmr_q == STEPOFF_LAST) state_d = SETTLE;
      end
    endcase
    // Steering withdrawn: leaving the enabled pair for either non-enabled state.
    lost_d = ((state_q == STEER) || (state_q == STEPOFF)) &&
             ((state_d == IDLE)  || (state_d == SETTLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      rider_off  <= 1'b1;
      en_steer   <= 1'b0;
      steer_lost <= 1'b0;
    end else begin
      state_q <= state_d;
      // Timer restarts on any state entry; otherwise counts and sticks at all-ones.
      if ((state_d != state_q) || tmr_clr) tmr_q <= '0;
      else if (tmr_q != '1)                tmr_q <= tmr_q + TMR_W'(1);
      rider_off  <= (state_d == IDLE);
      en_steer   <= (state_d == STEER) || (state_d == STEPOFF);
      steer_lost <= lost_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_steer_en_gen.sv
// tb/tb_steer_en_gen.sv - self-checking bench for steer_en_gen (FAST_SIM, default thresholds)
module tb_steer_en_gen;

  localparam int HI_TH  = 'h200 + 'h40;
  localparam int LO_TH  = 'h200 - 'h40;
  localparam int SET_N  = 32768;
  localparam int STP_N  = 64;
  localparam int TMAX   = 32767;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_steer, rider_off, steer_lost;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  steer_en_gen_if #(.LD_W(12)) ld_if ();

  steer_en_gen #(
    .LD_W         (12),
    .MIN_RIDER_WT ('h200),
    .WT_HYST      ('h40),
    .SETTLE_CYC   (67_000_000),
    .STEPOFF_CYC  (1_000_000),
    .FAST_SIM     (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_if      (ld_if),
    .en_steer   (en_steer),
    .rider_off  (rider_off),
    .steer_lost (steer_lost),
    .state_o    (state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: state as 0..3, elapsed cycles in state, flags from plain arithmetic.
  int m_state = 0;
  int m_timer = 0;
  bit m_gt = 0, m_lt = 0, m_d14 = 0, m_d1516 = 0;
  bit m_lost = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input int l, input int r, input bit rs);
    int  ns;
    bit  restart;
    int  s, a;
    if (rs) begin
      m_state = 0; m_timer = 0; m_lost = 0;
      m_gt = 0; m_lt = 0; m_d14 = 0; m_d1516 = 0;
      return;
    end
    ns = m_state;
    restart = 0;
    case (m_state)
      0: if (m_gt) ns = 1;
      1: if (m_lt) ns = 0; else if (m_d14) restart = 1; else if (m_timer == SET_N - 1) ns = 2;
      2: if (m_lt) ns = 0; else if (m_d1516) ns = 3;
      default: if (m_lt) ns = 0; else if (!m_d1516) ns = 2; else if (m_timer == STP_N - 1) ns = 1;
    endcase
    m_lost = (m_state >= 2) && (ns <= 1);
    if (ns != m_state || restart) m_timer = 0;
    else if (m_timer < TMAX)      m_timer++;
    m_state = ns;
    if (v) begin
      s = l + r;
      a = (l > r) ? l - r : r - l;
      m_gt    = s > HI_TH;
      m_lt    = s < LO_TH;
      m_d14   = a > s / 4;
      m_d1516 = a > s - s / 16;
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare all outputs 1 ns later.
  task automatic cyc(input bit v, input int l, input int r, input bit rs);
    logic [4:0] act, exp;
    logic [1:0] mst;
    ld_if.ld_vld  = v;
    ld_if.lft_ld  = l[11:0];
    ld_if.rght_ld = r[11:0];
    rst = rs;
    @(posedge clk);
    model_step(v, l, r, rs);
    #1;
    mst = 2'(m_state);
    act = {en_steer, rider_off, steer_lost, state_o};
    exp = {(m_state >= 2), (m_state == 0), m_lost, mst};
    check("model", {27'd0, act}, {27'd0, exp});
  endtask

  typedef struct {
    int lft;
    int rght;
    int exp_state;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt, guard, lost_cnt, cls, hold, bl, br;
    bit step_seen, en_drop;

    vecs[0] = '{'h080, 'h080, 0};   // well below band
    vecs[1] = '{'h100, 'h100, 0};   // 0x200 inside hysteresis band
    vecs[2] = '{'h120, 'h120, 0};   // 0x240 exactly at upper edge, strict
    vecs[3] = '{'h121, 'h120, 1};   // 0x241 just above
    vecs[4] = '{'h150, 'h150, 1};   // balanced rider
    vecs[5] = '{'h2A0, 'h000, 1};   // heavy but one-sided: IDLE only looks at gt
    vecs[6] = '{'hFFF, 'h001, 1};   // 0x1000 needs the carry bit
    vecs[7] = '{'h0DF, 'h0E0, 0};   // 0x1BF below lower edge

    ld_if.ld_vld = 1'b0; ld_if.lft_ld = '0; ld_if.rght_ld = '0; rst = 1'b1;

    // Reset values
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst_state", {30'd0, state_o}, 0);
    check("rst_rider_off", {31'd0, rider_off}, 1);
    check("rst_en_steer", {31'd0, en_steer}, 0);
    check("rst_steer_lost", {31'd0, steer_lost}, 0);

    // Light load held: stays IDLE
    repeat (50) cyc(1, 'h080, 'h080, 0);
    check("light_idle", {29'd0, rider_off, en_steer, state_o}, {29'd0, 1'b1, 1'b0, 2'd0});

    // Threshold table, each from a fresh reset
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1);
      repeat (3) cyc(1, vecs[i].lft, vecs[i].rght, 0);
      check($sformatf("vec%0d_state", i), {30'd0, state_o}, vecs[i].exp_state);
      check($sformatf("vec%0d_off", i), {31'd0, rider_off}, (vecs[i].exp_state == 0) ? 1 : 0);
    end

    // Randomised bursts of load classes with sparse strobes, checked against the model
    cyc(0, 0, 0, 1);
    cnt = 0;
    while (cnt < 500) begin
      cls  = $urandom_range(0, 3);
      hold = $urandom_range(1, 20);
      for (int k = 0; k < hold; k++) begin
        case (cls)
          0: begin bl = $urandom_range(0, 'h0E0); br = $urandom_range(0, 'h0E0); end
          1: begin bl = $urandom_range('h0E0, 'h120); br = $urandom_range('h0E0, 'h120); end
          2: begin bl = $urandom_range('h130, 'h400); br = bl + $urandom_range(0, 'h20); end
          default: begin bl = $urandom_range(0, 'hFFF); br = $urandom_range(0, 'h0FF); end
        endcase
        cyc(($urandom_range(0, 3) != 0), bl, br, 0);
        cnt++;
      end
    end

    // Undisturbed settle lasts exactly SET_N cycles
    cyc(0, 0, 0, 1);
    guard = 0;
    while (state_o !== 2'd1 && guard < 10) begin cyc(1, 'h150, 'h150, 0); guard++; end
    check("settle_entry", {30'd0, state_o}, 1);
    cnt = 0;
    while (state_o === 2'd1 && cnt < 40000) begin cnt++; cyc(1, 'h150, 'h150, 0); end
    check("settle_len", cnt, SET_N);
    check("steer_en", {31'd0, en_steer}, 1);
    check("steer_rider_off", {31'd0, rider_off}, 0);

    // Band weight in STEER keeps steering
    repeat (50) cyc(1, 'h100, 'h100, 0);
    check("band_in_steer", {30'd0, state_o}, 2);

    // Brief heel lift: STEPOFF and back without losing steering
    step_seen = 0; en_drop = 0; lost_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k < 10) cyc(1, 'h2A0, 'h000, 0);
      else        cyc(1, 'h150, 'h150, 0);
      if (state_o === 2'd3) step_seen = 1;
      if (en_steer !== 1'b1) en_drop = 1;
      if (steer_lost !== 1'b0) lost_cnt++;
    end
    check("heel_stepoff_seen", {31'd0, step_seen}, 1);
    check("heel_en_drop", {31'd0, en_drop}, 0);
    check("heel_lost", lost_cnt, 0);
    check("heel_back_steer", {30'd0, state_o}, 2);

    // Step-off held: STEPOFF for exactly STP_N cycles, one steer_lost pulse
    cnt = 0; lost_cnt = 0; guard = 0;
    while (state_o !== 2'd1 && guard < 200) begin
      cyc(1, 'h2A0, 'h000, 0);
      guard++;
      if (state_o === 2'd3) cnt++;
      if (steer_lost === 1'b1) lost_cnt++;
    end
    repeat (5) begin
      cyc(1, 'h2A0, 'h000, 0);
      if (steer_lost === 1'b1) lost_cnt++;
    end
    check("stepoff_len", cnt, STP_N);
    check("stepoff_lost_once", lost_cnt, 1);
    check("stepoff_en", {31'd0, en_steer}, 0);
    check("stepoff_to_settle", {30'd0, state_o}, 1);

    // Single imbalanced sample during SETTLE restarts the full count
    repeat (50) cyc(1, 'h150, 'h150, 0);
    check("pre_restart_settle", {30'd0, state_o}, 1);
    cyc(1, 'h200, 'h080, 0);
    cnt = 0;
    while (en_steer !== 1'b1 && cnt < 40000) begin cnt++; cyc(1, 'h150, 'h150, 0); end
    check("restart_delay", cnt, SET_N + 1);

    // Weight drop with d1516 together: lt wins, straight to IDLE
    cyc(1, 'h1B0, 'h000, 0);
    check("drop_flag_edge_state", {30'd0, state_o}, 2);
    cyc(1, 'h1B0, 'h000, 0);
    check("drop_state", {30'd0, state_o}, 0);
    check("drop_lost", {31'd0, steer_lost}, 1);
    check("drop_rider_off", {31'd0, rider_off}, 1);
    cyc(1, 'h1B0, 'h000, 0);
    check("drop_lost_cleared", {31'd0, steer_lost}, 0);

    // Band weight from IDLE stays IDLE
    repeat (50) cyc(1, 'h100, 'h100, 0);
    check("band_in_idle", {30'd0, state_o}, 0);

    // Back to STEER, then reset while in STEPOFF
    guard = 0;
    while (en_steer !== 1'b1 && guard < 40000) begin cyc(1, 'h150, 'h150, 0); guard++; end
    check("resteer", {30'd0, state_o}, 2);
    repeat (3) cyc(1, 'h2A0, 'h000, 0);
    check("pre_rst_stepoff", {30'd0, state_o}, 3);
    cyc(1, 'h2A0, 'h000, 1);
    check("mid_rst_state", {30'd0, state_o}, 0);
    check("mid_rst_off", {31'd0, rider_off}, 1);
    check("mid_rst_en", {31'd0, en_steer}, 0);
    check("mid_rst_lost", {31'd0, steer_lost}, 0);
    cyc(0, 0, 0, 0);
    check("post_rst_lost", {31'd0, steer_lost}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
